// File: rtl/wb_dma_copy.sv
// Wishbone word-copy DMA engine.
// A classic responder port exposes SRC/DST/LEN/CTRL. A classic initiator
// port copies LEN 32-bit words from SRC to DST, one read followed by one
// write per word. A level interrupt is raised on completion.
module wb_dma_copy #(
    parameter int LEN_WIDTH = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    // responder port
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic        wbs_we_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    // initiator port
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    output logic        irq_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t               state;
    state_t               state_next;

    logic [31:0]          src;
    logic [31:0]          dst;
    logic [LEN_WIDTH-1:0] len;
    logic [31:0]          data_buf;
    logic                 done;
    logic                 err;
    logic                 ie;
    logic                 abort_pend;

    logic                 access;
    logic                 reg_wr;
    logic                 ctrl_wr;
    logic                 start_req;
    logic                 abort_req;
    logic                 busy;
    logic                 abort_hit;
    logic                 len_last;
    logic [31:0]          reg_rdata;

    // Only address bits [3:2] are decoded and byte selects are ignored.
    logic                 unused_inputs;
    assign unused_inputs = ^{wbs_sel_i, wbs_adr_i[31:4], wbs_adr_i[1:0]};

    // A responder access is taken once per request: the ack register gates
    // the next one, so ack is never high for two cycles in a row.
    assign access    = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign reg_wr    = access & wbs_we_i;
    assign ctrl_wr   = reg_wr & (wbs_adr_i[3:2] == 2'd3);
    assign start_req = ctrl_wr & wbs_dat_i[0];
    assign abort_req = ctrl_wr & wbs_dat_i[5];

    assign busy      = (state != IDLE);
    assign abort_hit = abort_pend | (abort_req & busy);
    assign len_last  = (len == LEN_WIDTH'(1));

    assign irq_o     = done & ie;
    assign wbm_sel_o = 4'hF;

    // Live register read mux.
    always_comb begin
        reg_rdata = 32'd0;
        case (wbs_adr_i[3:2])
            2'd0:    reg_rdata = src;
            2'd1:    reg_rdata = dst;
            2'd2:    reg_rdata = {{(32 - LEN_WIDTH){1'b0}}, len};
            default: reg_rdata = {26'd0, 1'b0, ie, err, done, busy, 1'b0};
        endcase
    end

    // Responder handshake: single-cycle ack with read data captured alongside.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= 32'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            wbs_ack_o <= access;
            if (access) begin
                wbs_dat_o <= reg_rdata;
            end
        end
    end

    // Initiator state register; reset drops cyc/stb immediately.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and initiator bus outputs, decoded from the current state.
    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred
        // on paths that do not assign it.
        state_next = state;
        wbm_cyc_o  = 1'b0;
        wbm_stb_o  = 1'b0;
        wbm_we_o   = 1'b0;
        wbm_adr_o  = 32'd0;
        wbm_dat_o  = 32'd0;
        case (state)
            IDLE: begin
                if (start_req && (len != '0)) begin
                    state_next = RD;
                end
            end
            RD: begin
                wbm_cyc_o = 1'b1;
                wbm_stb_o = 1'b1;
                wbm_adr_o = src;
                if (wbm_err_i) begin
                    state_next = IDLE;
                end else if (wbm_ack_i) begin
                    state_next = WR;
                end
            end
            WR: begin
                wbm_cyc_o = 1'b1;
                wbm_stb_o = 1'b1;
                wbm_we_o  = 1'b1;
                wbm_adr_o = dst;
                wbm_dat_o = data_buf;
                if (wbm_err_i) begin
                    state_next = IDLE;
                end else if (wbm_ack_i) begin
                    state_next = (len_last || abort_hit) ? IDLE : GAP;
                end
            end
            GAP: begin
                state_next = abort_hit ? IDLE : RD;
            end
        endcase
    end

    // Programmable registers and transfer bookkeeping. Engine events are
    // placed after register writes so a completion wins over a W1C of DONE.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            src        <= 32'd0;
            dst        <= 32'd0;
            len        <= '0;
            data_buf   <= 32'd0;
            done       <= 1'b0;
            err        <= 1'b0;
            ie         <= 1'b0;
            abort_pend <= 1'b0;
        end else begin
            if (reg_wr) begin
                case (wbs_adr_i[3:2])
                    2'd0: if (!busy) src <= {wbs_dat_i[31:2], 2'b00};
                    2'd1: if (!busy) dst <= {wbs_dat_i[31:2], 2'b00};
                    2'd2: if (!busy) len <= wbs_dat_i[LEN_WIDTH-1:0];
                    default: begin
                        ie <= wbs_dat_i[4];
                        if (wbs_dat_i[2]) done <= 1'b0;
                        if (wbs_dat_i[3]) err  <= 1'b0;
                    end
                endcase
            end

            case (state)
                IDLE: begin
                    if (start_req) begin
                        if (len != '0) begin
                            done <= 1'b0;
                            err  <= 1'b0;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RD: begin
                    if (wbm_err_i) begin
                        err  <= 1'b1;
                        done <= 1'b1;
                    end else if (wbm_ack_i) begin
                        data_buf <= wbm_dat_i;
                    end
                end
                WR: begin
                    if (wbm_err_i) begin
                        err  <= 1'b1;
                        done <= 1'b1;
                    end else if (wbm_ack_i) begin
                        src <= src + 32'd4;
                        dst <= dst + 32'd4;
                        len <= len - LEN_WIDTH'(1);
                        if (len_last || abort_hit) begin
                            done <= 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (abort_hit) begin
                        done <= 1'b1;
                    end
                end
            endcase

            // Abort is remembered only while a transfer is running.
            abort_pend <= (state_next != IDLE) && (abort_pend || (abort_req && busy));
        end
    end

endmodule

// File: tb/tb_wb_dma_copy.sv
// Self-checking bench for wb_dma_copy: a Wishbone slave model answers the
// initiator port, expected writes are queued as each copy is programmed and
// compared as the DUT's write cycles are acknowledged.
module tb_wb_dma_copy;

    logic        wb_clk_i;
    logic        wb_rst_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic [3:0]  wbs_sel_i;
    logic        wbs_we_i;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_ack_i;
    logic        wbm_err_i;
    logic        irq_o;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
    } wr_item_t;

    wr_item_t exp_q[$];

    int wr_seen      = 0;  // write responses issued by the slave
    int err_at_write = 0;  // 0 = never, else the write number that gets err
    int cyc_cycles   = 0;  // cycles with wbm_cyc_o high

    wb_dma_copy #(.LEN_WIDTH(16)) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_stb_i (wbs_stb_i),
        .wbs_dat_o (wbs_dat_o),
        .wbs_ack_o (wbs_ack_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_dat_i (wbm_dat_i),
        .wbm_sel_o (wbm_sel_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_ack_i (wbm_ack_i),
        .wbm_err_i (wbm_err_i),
        .irq_o     (irq_o)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Memory contents as seen by the copy engine: a fixed function of address.
    function automatic logic [31:0] pat(input logic [31:0] a);
        return {a[15:0] ^ 16'h5AC3, ~a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Slave model: registered single-cycle ack (or err on a chosen write).
    always @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbm_ack_i <= 1'b0;
            wbm_err_i <= 1'b0;
            wbm_dat_i <= 32'd0;
        end else begin
            wbm_ack_i <= 1'b0;
            wbm_err_i <= 1'b0;
            if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i && !wbm_err_i) begin
                if (wbm_we_o) begin
                    wr_seen <= wr_seen + 1;
                    if (err_at_write != 0 && wr_seen + 1 == err_at_write)
                        wbm_err_i <= 1'b1;
                    else
                        wbm_ack_i <= 1'b1;
                end else begin
                    wbm_ack_i <= 1'b1;
                    wbm_dat_i <= pat(wbm_adr_o);
                end
            end
        end
    end

    // Scoreboard side: each acknowledged write is popped and compared.
    always @(negedge wb_clk_i) begin
        if (!wb_rst_i) begin
            if (wbm_cyc_o) cyc_cycles++;
            if (wbm_cyc_o && wbm_stb_o && wbm_we_o && wbm_ack_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write_adr", wbm_adr_o, 32'hFFFF_FFFF);
                end else begin
                    wr_item_t it;
                    it = exp_q.pop_front();
                    check("copy_wr_adr", wbm_adr_o, it.adr);
                    check("copy_wr_dat", wbm_dat_o, it.dat);
                end
            end
        end
    end

    // Responder access helpers; all start and end at posedge + 1.
    task automatic wb_access(input logic [1:0] reg_idx, input logic we, input logic [31:0] wdat,
                             input bit hold, output logic [31:0] rdat);
        bit got;
        got       = 1'b0;
        wbs_adr_i = {28'd0, reg_idx, 2'b00};
        wbs_dat_i = wdat;
        wbs_we_i  = we;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge wb_clk_i);
            #1;
            if (wbs_ack_o) begin
                got = 1'b1;
                break;
            end
        end
        rdat = wbs_dat_o;
        if (!got) check("wbs_ack_timeout", {31'd0, wbs_ack_o}, 32'd1);
        if (hold) begin
            @(posedge wb_clk_i);
            #1;
            check("wbs_ack_one_cycle", {31'd0, wbs_ack_o}, 32'd0);
        end
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
    endtask

    task automatic wb_write(input logic [1:0] reg_idx, input logic [31:0] wdat);
        logic [31:0] dummy;
        wb_access(reg_idx, 1'b1, wdat, 1'b0, dummy);
    endtask

    task automatic wb_read(input logic [1:0] reg_idx, output logic [31:0] rdat);
        wb_access(reg_idx, 1'b0, 32'd0, 1'b0, rdat);
    endtask

    task automatic push_copy(input logic [31:0] s, input logic [31:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            wr_item_t it;
            it.adr = d + 32'(4 * i);
            it.dat = pat(s + 32'(4 * i));
            exp_q.push_back(it);
        end
    endtask

    task automatic wait_done(output logic [31:0] ctrl);
        ctrl = 32'd0;
        for (int i = 0; i < 100; i++) begin
            wb_read(2'd3, ctrl);
            if (ctrl[2]) break;
        end
        check("done_seen", {31'd0, ctrl[2]}, 32'd1);
    endtask

    initial begin
        logic [31:0] v;
        int          snap;

        wb_rst_i  = 1'b1;
        wbs_adr_i = 32'd0;
        wbs_dat_i = 32'd0;
        wbs_sel_i = 4'hF;
        wbs_we_i  = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;

        // Reset state
        #1;
        check("rst_cyc", {31'd0, wbm_cyc_o}, 32'd0);
        check("rst_ack", {31'd0, wbs_ack_o}, 32'd0);
        check("rst_irq", {31'd0, irq_o}, 32'd0);
        check("rst_adr", wbm_adr_o, 32'd0);
        check("sel_const", {28'd0, wbm_sel_o}, 32'hF);
        @(posedge wb_clk_i);
        @(posedge wb_clk_i);
        #1;
        wb_rst_i = 1'b0;
        wb_read(2'd3, v);
        check("rst_ctrl", v, 32'd0);
        wb_read(2'd2, v);
        check("rst_len", v, 32'd0);

        // Basic 4-word copy with interrupt; also low-bit forcing and LEN width
        wb_write(2'd0, 32'h0000_0103);
        wb_read(2'd0, v);
        check("src_low_bits", v, 32'h0000_0100);
        wb_write(2'd1, 32'h0000_0202);
        wb_read(2'd1, v);
        check("dst_low_bits", v, 32'h0000_0200);
        wb_write(2'd2, 32'hABCD_0004);
        wb_read(2'd2, v);
        check("len_upper_zero", v, 32'h0000_0004);
        push_copy(32'h100, 32'h200, 4);
        wb_write(2'd3, 32'h11);
        wait_done(v);
        check("copy_ctrl", v, 32'h14);
        check("copy_irq", {31'd0, irq_o}, 32'd1);
        wb_read(2'd2, v);
        check("copy_len", v, 32'd0);
        wb_read(2'd0, v);
        check("copy_src", v, 32'h110);
        wb_read(2'd1, v);
        check("copy_dst", v, 32'h210);
        check("copy_q_empty", 32'(exp_q.size()), 32'd0);
        wb_write(2'd3, 32'h4);
        check("irq_cleared", {31'd0, irq_o}, 32'd0);

        // LEN == 0: DONE the cycle after START, no bus activity
        snap = cyc_cycles;
        wb_write(2'd3, 32'h11);
        check("len0_irq", {31'd0, irq_o}, 32'd1);
        repeat (4) @(posedge wb_clk_i);
        #1;
        check("len0_no_cyc", 32'(cyc_cycles), 32'(snap));
        wb_write(2'd3, 32'h4);

        // Bus error on the 2nd write of a 3-word copy
        wb_write(2'd0, 32'h300);
        wb_write(2'd1, 32'h200);
        wb_write(2'd2, 32'd3);
        push_copy(32'h300, 32'h200, 1);
        err_at_write = wr_seen + 2;
        wb_write(2'd3, 32'h1);
        wait_done(v);
        check("err_ctrl", v, 32'h0C);
        wb_read(2'd2, v);
        check("err_len", v, 32'd2);
        wb_read(2'd1, v);
        check("err_dst", v, 32'h204);
        wb_read(2'd0, v);
        check("err_src", v, 32'h304);
        snap = cyc_cycles;
        repeat (10) @(posedge wb_clk_i);
        #1;
        check("err_no_more_cyc", 32'(cyc_cycles), 32'(snap));
        check("err_q_empty", 32'(exp_q.size()), 32'd0);
        err_at_write = 0;
        wb_write(2'd3, 32'hC);

        // ABORT during the read of word 2 of an 8-word copy
        wb_write(2'd0, 32'h400);
        wb_write(2'd1, 32'h500);
        wb_write(2'd2, 32'd8);
        push_copy(32'h400, 32'h500, 2);
        wb_write(2'd3, 32'h1);
        for (int i = 0; i < 60; i++) begin
            if (wbm_cyc_o && !wbm_we_o && wbm_adr_o == 32'h404) break;
            @(posedge wb_clk_i);
            #1;
        end
        check("abort_saw_rd2", wbm_adr_o, 32'h404);
        wb_write(2'd3, 32'h20);
        wait_done(v);
        check("abort_ctrl", v, 32'h04);
        wb_read(2'd2, v);
        check("abort_len", v, 32'd6);
        wb_read(2'd0, v);
        check("abort_src", v, 32'h408);
        check("abort_q_empty", 32'(exp_q.size()), 32'd0);
        wb_write(2'd3, 32'h4);

        // Register writes and START while busy are ignored
        wb_write(2'd0, 32'h600);
        wb_write(2'd1, 32'h700);
        wb_write(2'd2, 32'd3);
        push_copy(32'h600, 32'h700, 3);
        wb_write(2'd3, 32'h1);
        wb_write(2'd0, 32'hDEAD_0000);
        wb_write(2'd3, 32'h1);
        wb_access(2'd3, 1'b0, 32'd0, 1'b1, v);
        check("busy_bit", v, 32'h2);
        wait_done(v);
        check("busy_ctrl", v, 32'h04);
        wb_read(2'd0, v);
        check("busy_src", v, 32'h60C);
        wb_read(2'd2, v);
        check("busy_len", v, 32'd0);
        check("busy_q_empty", 32'(exp_q.size()), 32'd0);
        wb_write(2'd3, 32'h4);

        // Asynchronous reset in the middle of a write cycle
        wb_write(2'd0, 32'h800);
        wb_write(2'd1, 32'h900);
        wb_write(2'd2, 32'd4);
        wb_write(2'd3, 32'h11);
        for (int i = 0; i < 60; i++) begin
            if (wbm_cyc_o && wbm_we_o) break;
            @(posedge wb_clk_i);
            #1;
        end
        check("rst_saw_wr", {31'd0, wbm_we_o}, 32'd1);
        #2;
        wb_rst_i = 1'b1;
        #1;
        check("async_rst_cyc", {31'd0, wbm_cyc_o}, 32'd0);
        check("async_rst_stb", {31'd0, wbm_stb_o}, 32'd0);
        @(posedge wb_clk_i);
        #1;
        wb_rst_i = 1'b0;
        wb_read(2'd0, v);
        check("post_rst_src", v, 32'd0);
        wb_read(2'd1, v);
        check("post_rst_dst", v, 32'd0);
        wb_read(2'd2, v);
        check("post_rst_len", v, 32'd0);
        wb_read(2'd3, v);
        check("post_rst_ctrl", v, 32'd0);
        check("post_rst_irq", {31'd0, irq_o}, 32'd0);
        check("final_q_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
